// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the CPU load/store memory access controller.
// Op encoding, FSM states, memory command payload and byte-lane helpers.
package mem_access_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned BE_W            = DATA_W / 8;
    localparam int unsigned DEF_MEM_TIMEOUT = 16;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Payload presented on the memory port for the whole ACCESS phase.
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    function automatic logic op_is_store(mem_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic op_is_half(mem_op_e op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

    function automatic logic op_is_word(mem_op_e op);
        return op inside {OP_LW, OP_SW};
    endfunction

    function automatic logic misaligned(mem_op_e op, logic [1:0] addr_lo);
        return (op_is_half(op) && addr_lo[0]) || (op_is_word(op) && (addr_lo != 2'b00));
    endfunction

    // Little-endian byte enables for the addressed lanes.
    function automatic logic [BE_W-1:0] lane_enables(mem_op_e op, logic [1:0] addr_lo);
        logic [BE_W-1:0] be;
        if (op_is_word(op)) begin
            be = 4'b1111;
        end else if (op_is_half(op)) begin
            be = addr_lo[1] ? 4'b1100 : 4'b0011;
        end else begin
            be = 4'b0001 << addr_lo;
        end
        return be;
    endfunction

    // Store data replicated across all lanes so memory can pick by byte enable.
    function automatic logic [DATA_W-1:0] lane_data(mem_op_e op, logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] d;
        case (op)
            OP_SB:   d = {4{wdata[7:0]}};
            OP_SH:   d = {2{wdata[15:0]}};
            OP_SW:   d = wdata;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load data path: picks the addressed byte/halfword lane of the memory word
// and sign- or zero-extends it; stores yield zero.
module load_align_ext
    import mem_access_pkg::*;
(
    input  mem_op_e           op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data_c    = '0;
        case (op)
            OP_LB:   data_c = {{24{byte_lane[7]}}, byte_lane};
            OP_LH:   data_c = {{16{half_lane[15]}}, half_lane};
            OP_LW:   data_c = rdata;
            OP_LBU:  data_c = {24'd0, byte_lane};
            OP_LHU:  data_c = {16'd0, half_lane};
            default: data_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU load/store controller: one access at a time, IDLE -> ACCESS -> RESP.
// Optional MEM_ACCESS_TIMEOUT_EN bounds the wait for mem_ack to MEM_TIMEOUT cycles.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall
);

    if (MEM_TIMEOUT == 0) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    state_e            state, state_n;
    mem_op_e           op_q, op_n;
    logic [1:0]        lo_q, lo_n;
    mem_cmd_t          cmd_q, cmd_n;
    logic              req_ready_n, stall_n, mem_cs_n, mem_we_n;
    logic              rsp_valid_n, rsp_err_n;
    logic [DATA_W-1:0] rsp_rdata_n;
    logic [DATA_W-1:0] load_data_c;
    mem_op_e           req_op_c;
    logic              req_misaligned_c;
    logic              timeout_c;

    assign req_op_c         = mem_op_e'(req_op);
    assign req_misaligned_c = misaligned(req_op_c, req_addr[1:0]);

    load_align_ext u_load_align_ext (
        .op      (op_q),
        .addr_lo (lo_q),
        .rdata   (mem_rdata),
        .data_c  (load_data_c)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts ACCESS cycles; held at zero in every other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_ACCESS) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_c = (state == ST_ACCESS) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n     = state;
        op_n        = op_q;
        lo_n        = lo_q;
        cmd_n       = cmd_q;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = rsp_rdata;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_misaligned_c) begin
                        state_n     = ST_RESP;
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = '0;
                    end else begin
                        state_n     = ST_ACCESS;
                        op_n        = req_op_c;
                        lo_n        = req_addr[1:0];
                        cmd_n.we    = op_is_store(req_op_c);
                        cmd_n.be    = lane_enables(req_op_c, req_addr[1:0]);
                        cmd_n.addr  = {req_addr[ADDR_W-1:2], 2'b00};
                        cmd_n.wdata = lane_data(req_op_c, req_wdata);
                    end
                end
            end
            ST_ACCESS: begin
                // An ack in the last permitted cycle still completes normally.
                if (mem_ack) begin
                    state_n     = ST_RESP;
                    rsp_rdata_n = load_data_c;
                end else if (timeout_c) begin
                    state_n     = ST_RESP;
                    rsp_err_n   = 1'b1;
                    rsp_rdata_n = '0;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        req_ready_n = (state_n == ST_IDLE);
        stall_n     = (state_n != ST_IDLE);
        mem_cs_n    = (state_n == ST_ACCESS);
        mem_we_n    = mem_cs_n && cmd_n.we;
        rsp_valid_n = (state_n == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_LB;
            lo_q      <= '0;
            cmd_q     <= '0;
            req_ready <= 1'b1;
            stall     <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            op_q      <= op_n;
            lo_q      <= lo_n;
            cmd_q     <= cmd_n;
            req_ready <= req_ready_n;
            stall     <= stall_n;
            mem_cs    <= mem_cs_n;
            mem_we    <= mem_we_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

    assign mem_be    = cmd_q.be;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level model plus
// per-cycle compare, with hand-computed literals for each directed vector.
module tb_mem_access_ctrl;

    localparam int TO = 16;
`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_cs;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall)
    );

    int checks = 0;
    int errors = 0;

    logic        cmp_en = 1'b0;
    logic        exp_ready, exp_stall, exp_cs, exp_we, exp_rv, exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: access size in bytes, derived from the op mnemonic.
    function automatic int op_size(logic [2:0] op);
        case (op)
            3'd0, 3'd3, 3'd5: return 1;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic m_store(logic [2:0] op);
        return op >= 3'd5;
    endfunction

    function automatic logic m_misaligned(logic [2:0] op, logic [31:0] addr);
        return (int'(addr[1:0]) % op_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] op, logic [31:0] addr);
        return 4'(((1 << op_size(op)) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] op, logic [31:0] wdata);
        logic [31:0] r;
        int s;
        s = op_size(op);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] op, logic [31:0] addr, logic [31:0] rdata);
        logic [31:0] mask;
        logic [31:0] v;
        int s;
        s    = op_size(op);
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
        v    = (rdata >> (8 * int'(addr[1:0]))) & mask;
        if ((op == 3'd0 || op == 3'd1) && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_idle();
        exp_ready = 1'b1; exp_stall = 1'b0; exp_cs = 1'b0; exp_we = 1'b0; exp_rv = 1'b0;
    endtask

    task automatic set_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        exp_ready = 1'b0; exp_stall = 1'b1; exp_cs = 1'b1; exp_we = m_store(op); exp_rv = 1'b0;
        exp_be    = m_be(op, addr);
        exp_addr  = addr & ~32'd3;
        exp_wdata = m_wdata(op, wdata);
    endtask

    task automatic set_resp(input logic err, input logic [31:0] rd);
        exp_ready = 1'b0; exp_stall = 1'b1; exp_cs = 1'b0; exp_we = 1'b0; exp_rv = 1'b1;
        exp_err   = err;
        exp_rdata = rd;
    endtask

    // Single compare process: DUT against model on every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("mem_cs", 32'(mem_cs), 32'(exp_cs));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            if (exp_cs) begin
                chk("mem_be", 32'(mem_be), 32'(exp_be));
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_rv) chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        logic        st;
        logic        done;
        logic        err_m;
        logic [31:0] rd_m;
        int          t;
        st = m_store(v.op);
        step();
        req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        mem_ack = 1'b0; mem_rdata = $urandom;
        set_idle();
        step();
        req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (m_misaligned(v.op, v.addr)) begin
            set_resp(1'b1, 32'd0);
            @(negedge clk); #1;
            chk("lit_err", 32'(rsp_err), 32'(v.err));
            chk("lit_rdata", rsp_rdata, v.rd);
        end else begin
            t = 1; done = 1'b0; err_m = 1'b0; rd_m = '0;
            while (!done) begin
                set_access(v.op, v.addr, v.wdata);
                mem_ack   = (t == v.ack_at);
                mem_rdata = mem_ack ? v.rdata : $urandom;
                if (t == 1) begin
                    @(negedge clk); #1;
                    chk("lit_be", 32'(mem_be), 32'(v.be));
                    if (st) chk("lit_wdata", mem_wdata, v.wd);
                end
                if (mem_ack) begin
                    err_m = 1'b0; rd_m = st ? 32'd0 : m_load(v.op, v.addr, v.rdata); done = 1'b1;
                end else if (TO_EN && t == TO) begin
                    err_m = 1'b1; rd_m = 32'd0; done = 1'b1;
                end else if (t >= 100) begin
                    chk("txn_bound", 32'(t), 32'(v.ack_at));
                    err_m = 1'b0; rd_m = exp_rdata; done = 1'b1;
                end
                step();
                t++;
            end
            set_resp(err_m, rd_m);
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            @(negedge clk); #1;
            chk("lit_err", 32'(rsp_err), 32'(v.err));
            chk("lit_rdata", rsp_rdata, v.rd);
        end
        step();
        set_idle();
        mem_ack = 1'b1; mem_rdata = $urandom;
    endtask

    function automatic vec_t mk(logic [2:0] op, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, int ack_at, logic [3:0] be,
                                logic [31:0] wd, logic [31:0] rd, logic err);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack_at = ack_at;
        v.be = be; v.wd = wd; v.rd = rd; v.err = err;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        set_idle();
        exp_err = 1'b0; exp_be = '0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_cs", 32'(mem_cs), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        cmp_en = 1'b1;
        step();
        rst_n = 1'b1;

        vecs.push_back(mk(3'd0, 32'h0000_1003, 32'h0,         32'h80FF_FF12, 1, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0));
        vecs.push_back(mk(3'd4, 32'h0000_1002, 32'h0,         32'h8001_0000, 2, 4'b1100, 32'h0,         32'h0000_8001, 1'b0));
        vecs.push_back(mk(3'd6, 32'h0000_2000, 32'h1234_ABCD, 32'h0,         1, 4'b0011, 32'hABCD_ABCD, 32'h0,         1'b0));
        vecs.push_back(mk(3'd2, 32'h0000_0002, 32'h0,         32'h0,         1, 4'b0000, 32'h0,         32'h0,         1'b1));
        vecs.push_back(mk(3'd1, 32'h0000_0006, 32'h0,         32'h8765_4321, 3, 4'b1100, 32'h0,         32'hFFFF_8765, 1'b0));
        vecs.push_back(mk(3'd1, 32'h0000_0001, 32'h0,         32'h0,         1, 4'b0000, 32'h0,         32'h0,         1'b1));
        vecs.push_back(mk(3'd3, 32'h0000_0005, 32'h0,         32'h1234_F000, 2, 4'b0010, 32'h0,         32'h0000_00F0, 1'b0));
        vecs.push_back(mk(3'd5, 32'h0000_0102, 32'h0000_00A5, 32'h0,         2, 4'b0100, 32'hA5A5_A5A5, 32'h0,         1'b0));
        vecs.push_back(mk(3'd7, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         1, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0));
        vecs.push_back(mk(3'd2, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 4, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0));
        vecs.push_back(mk(3'd5, 32'h0000_0003, 32'h0000_1234, 32'h0,         1, 4'b1000, 32'h3434_3434, 32'h0,         1'b0));
        vecs.push_back(mk(3'd7, 32'h0000_0001, 32'h1111_2222, 32'h0,         1, 4'b0000, 32'h0,         32'h0,         1'b1));
        vecs.push_back(mk(3'd4, 32'h0000_0003, 32'h0,         32'h0,         1, 4'b0000, 32'h0,         32'h0,         1'b1));
        vecs.push_back(mk(3'd0, 32'h0000_0000, 32'h0,         32'h0000_007F, 1, 4'b0001, 32'h0,         32'h0000_007F, 1'b0));
        vecs.push_back(mk(3'd2, 32'h0000_0020, 32'h0,         32'h5A5A_0F0F, TO, 4'b1111, 32'h0,        32'h5A5A_0F0F, 1'b0));
        if (TO_EN)
            vecs.push_back(mk(3'd2, 32'h0000_0010, 32'h0, 32'h1111_1111, 0, 4'b1111, 32'h0, 32'h0, 1'b1));
        else
            vecs.push_back(mk(3'd2, 32'h0000_0010, 32'h0, 32'h1111_1111, 40, 4'b1111, 32'h0, 32'h1111_1111, 1'b0));

        foreach (vecs[i]) run_txn(vecs[i]);

        // Reset in the middle of an access, then a late ack that must be ignored.
        step();
        req_valid = 1'b1; req_op = 3'd2; req_addr = 32'h0000_0040; req_wdata = '0; mem_ack = 1'b0;
        set_idle();
        step();
        req_valid = 1'b0;
        set_access(3'd2, 32'h0000_0040, 32'h0);
        step();
        step();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_mem_cs", 32'(mem_cs), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
        set_idle();
        exp_rdata = 32'd0;
        step();
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        step();
        mem_ack = 1'b0;
        step();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max mem_ack wait cycles before error.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  CPU access request.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-006 SHALL have port req_op  input  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-011 SHALL have port rsp_err  output  1  misaligned or timed out; valid with rsp_valid.
REQ-012 SHALL have ports mem_cs / mem_we  output  1 / 1  memory select / write enable.
REQ-013 SHALL have ports mem_be / mem_addr / mem_wdata  output  4 / 32 / 32  byte enables / word address {addr[31:2],2'b00} / lane data.
REQ-014 SHALL have ports mem_rdata / mem_ack  input  32 / 1  read word / access done.
REQ-015 SHALL have port stall  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-017 IDLE: req_ready=1; on acceptance of an aligned request, latch op/addr/wdata and go to ACCESS; on a misaligned request, go to RESP with err=1 and issue no memory access.
REQ-018 Misaligned SHALL mean: halfword op with addr[0]=1, or word op with addr[1:0]!=00.
REQ-019 ACCESS: mem_cs=1 and mem_we=1 for stores; mem_addr/be/wdata held stable until mem_ack; on mem_ack go to RESP.
REQ-020 RESP: rsp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in ACCESS and RESP.
REQ-021 Latency: request accepted in cycle 0, mem_cs rises in cycle 1, ack in cycle k>=1 gives rsp_valid in cycle k+1; minimum latency is 2 cycles.
REQ-022 Byte lanes little-endian: byte be=4'b0001<<addr[1:0]; halfword be=addr[1]?4'b1100:4'b0011; word be=4'b1111.
REQ-023 Store data SHALL be replicated: SB {4{b}}, SH {2{h}}, SW as-is.
REQ-024 Load data SHALL be selected from the addressed lane, then sign-extended (LB, LH) or zero-extended (LBU, LHU) to 32 bits; LW passes through.
REQ-025 mem_ack outside ACCESS SHALL be ignored; rsp_rdata is registered and holds its value outside RESP.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, all outputs 0 except req_ready=1, and the timeout counter to 0.
REQ-027 Reset asserted mid-access SHALL abort it with no rsp_valid; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-028 With MEM_ACCESS_TIMEOUT_EN defined, a counter SHALL clear on ACCESS entry; if MEM_TIMEOUT cycles elapse without mem_ack, the FSM goes to RESP with err=1 and mem_cs drops.
REQ-029 Without MEM_ACCESS_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-030 Package mem_access_pkg SHALL hold the op encoding enum, state enum and default MEM_TIMEOUT.
REQ-031 Sub-module load_align_ext SHALL perform lane select plus sign/zero extension (combinational).

Verification
REQ-032 LB addr 0x1003, mem_rdata 0x80FF_FF12 with ack in first cycle: be=1000, rsp_rdata=0xFFFF_FF80 in cycle 2.
REQ-033 LHU addr 0x1002, mem_rdata 0x8001_0000: be=1100, rsp_rdata=0x0000_8001, err=0.
REQ-034 SH addr 0x2000, wdata 0x1234_ABCD: mem_we=1, be=0011, mem_wdata=0xABCD_ABCD, rsp_rdata=0.
REQ-035 LW addr 0x0002: no mem_cs; rsp_valid with err=1 in cycle 1.
REQ-036 With macro defined and no ack, MEM_TIMEOUT=16: rsp_err=1 after 16 ACCESS cycles; rst_n pulsed mid-ACCESS returns IDLE with no rsp_valid.
